// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO host port.
// Holds the register window layout, the STATUS field positions, the default
// window base and a helper that packs the STATUS word.
package mmio_pkg;

  // Default word-aligned base of the 3-register window.
  localparam logic [31:0] BASE_ADR_DEFAULT = 32'h0000_0100;

  // Byte offsets of the registers inside the window.
  localparam logic [31:0] TXDATA_OFF = 32'h0000_0000;
  localparam logic [31:0] STATUS_OFF = 32'h0000_0004;
  localparam logic [31:0] HALT_OFF   = 32'h0000_0008;

  // STATUS layout: {26'b0, overflow, count[4:0]}.
  localparam int unsigned STATUS_CNT_W   = 5;
  localparam int unsigned STATUS_OVF_BIT = 5;

  typedef enum logic [1:0] {
    RegTxData,
    RegStatus,
    RegHalt,
    RegNone
  } reg_sel_e;

  function automatic logic [31:0] status_word(input logic ovf,
                                              input logic [STATUS_CNT_W-1:0] cnt);
    logic [31:0] w;
    w = '0;
    w[STATUS_CNT_W-1:0] = cnt;
    w[STATUS_OVF_BIT]   = ovf;
    return w;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous single-clock FIFO.
// Ports:
//   clk, reset      - rising-edge clock, synchronous active-high reset
//   push, wdata     - enqueue request and data
//   pop             - dequeue request for the head entry
//   rdata           - head entry (don't-care while empty)
//   count           - number of stored entries
//   full, empty     - occupancy flags
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// A push while full is accepted only when a pop frees a slot in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned Aw = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [Aw:0]      wr_ptr_q, wr_ptr_d;
  logic [Aw:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  always_comb begin
    count   = wr_ptr_q - rd_ptr_q;
    full    = (count == (Aw + 1)'(DEPTH));
    empty   = (count == '0);
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
    wr_ptr_d = wr_ptr_q + {{Aw{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{Aw{1'b0}}, do_pop};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset; pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push && !reset) begin
      mem_q[wr_ptr_q[Aw-1:0]] <= wdata;
    end
  end

  assign rdata = mem_q[rd_ptr_q[Aw-1:0]];

endmodule

// File: rtl/mmio_host_port.sv
// Memory-mapped host port on the CPU data bus.
// Ports:
//   clk, reset          - rising-edge clock, synchronous active-high reset
//   MemWrite, DataAdr,
//   WriteData           - CPU store strobe, address and data
//   Hit, ReadData       - window hit and load data (combinational, 0 on miss)
//   HostValid, HostData,
//   HostReady           - valid/ready stream of words stored to TXDATA
//   Done, ExitCode      - sticky halt flag and last value stored to HALT
// Window: TXDATA (push), STATUS ({overflow, count}, store clears overflow),
// HALT (sets Done, latches ExitCode). DataAdr[1:0] is ignored.
module mmio_host_port
  import mmio_pkg::*;
#(
  parameter logic [31:0]  BASE_ADR = BASE_ADR_DEFAULT,
  parameter int unsigned  DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic        Hit,
  output logic [31:0] ReadData,
  output logic        HostValid,
  output logic [31:0] HostData,
  input  logic        HostReady,
  output logic        Done,
  output logic [31:0] ExitCode
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  reg_sel_e        sel;
  logic [29:0]     word_off;
  logic            wr_tx, wr_status, wr_halt;
  logic            pop;
  logic [CntW-1:0] count;
  logic            full, empty;
  logic            ovf_q, ovf_d;
  logic            done_q, done_d;
  logic [31:0]     exit_q, exit_d;
  logic            unused_adr;

  assign unused_adr = ^DataAdr[1:0];

  // Word offset from the base; out-of-window addresses fall through to RegNone.
  always_comb begin
    word_off = DataAdr[31:2] - BASE_ADR[31:2];
    if (word_off == TXDATA_OFF[31:2]) begin
      sel = RegTxData;
    end else if (word_off == STATUS_OFF[31:2]) begin
      sel = RegStatus;
    end else if (word_off == HALT_OFF[31:2]) begin
      sel = RegHalt;
    end else begin
      sel = RegNone;
    end
  end

  assign Hit       = (sel != RegNone);
  assign wr_tx     = MemWrite & (sel == RegTxData);
  assign wr_status = MemWrite & (sel == RegStatus);
  assign wr_halt   = MemWrite & (sel == RegHalt);
  assign pop       = HostValid & HostReady;

  sync_fifo #(
    .WIDTH(32),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (wr_tx),
    .pop  (pop),
    .wdata(WriteData),
    .rdata(HostData),
    .count(count),
    .full (full),
    .empty(empty)
  );

  assign HostValid = ~empty;

  always_comb begin
    ovf_d  = ovf_q;
    done_d = done_q;
    exit_d = exit_q;
    if (wr_status) begin
      ovf_d = 1'b0;
    end else if (wr_tx && full && !pop) begin
      // Dropped word: no slot frees up this cycle.
      ovf_d = 1'b1;
    end
    if (wr_halt) begin
      done_d = 1'b1;
      exit_d = WriteData;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q  <= 1'b0;
      done_q <= 1'b0;
      exit_q <= '0;
    end else begin
      ovf_q  <= ovf_d;
      done_q <= done_d;
      exit_q <= exit_d;
    end
  end

  always_comb begin
    unique case (sel)
      RegTxData: ReadData = '0;
      RegStatus: ReadData = status_word(ovf_q, STATUS_CNT_W'(count));
      RegHalt:   ReadData = exit_q;
      default:   ReadData = '0;
    endcase
  end

  assign Done     = done_q;
  assign ExitCode = exit_q;

endmodule

// File: tb/tb_mmio_host_port.sv
// Bench for mmio_host_port: a table of hand-derived steps followed by random
// traffic compared against a queue-based reference model.
module tb_mmio_host_port;

  localparam int unsigned Depth = 4;
  localparam logic [31:0] Base  = 32'h0000_0100;

  logic        clk;
  logic        reset;
  logic        mem_write;
  logic [31:0] data_adr;
  logic [31:0] write_data;
  logic        hit;
  logic [31:0] read_data;
  logic        host_valid;
  logic [31:0] host_data;
  logic        host_ready;
  logic        done;
  logic [31:0] exit_code;

  int checks = 0;
  int errors = 0;

  mmio_host_port #(
    .BASE_ADR(Base),
    .DEPTH   (Depth)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .MemWrite (mem_write),
    .DataAdr  (data_adr),
    .WriteData(write_data),
    .Hit      (hit),
    .ReadData (read_data),
    .HostValid(host_valid),
    .HostData (host_data),
    .HostReady(host_ready),
    .Done     (done),
    .ExitCode (exit_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic        rst;
    logic        we;
    logic [31:0] adr;
    logic [31:0] wd;
    logic        rdy;
    logic        hit;
    logic [31:0] rd;
    logic        val;
    logic [31:0] hd;
    logic        done;
    logic [31:0] ex;
  } vec_t;

  vec_t tbl[$];

  task automatic v(input logic rst, input logic we, input logic [31:0] adr,
                   input logic [31:0] wd, input logic rdy, input logic h,
                   input logic [31:0] rd, input logic val, input logic [31:0] hd,
                   input logic dn, input logic [31:0] ex);
    vec_t e;
    e.rst = rst; e.we = we; e.adr = adr; e.wd = wd; e.rdy = rdy;
    e.hit = h; e.rd = rd; e.val = val; e.hd = hd; e.done = dn; e.ex = ex;
    tbl.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic we, input logic [31:0] adr,
                       input logic [31:0] wd, input logic rdy);
    reset = rst; mem_write = we; data_adr = adr; write_data = wd; host_ready = rdy;
  endtask

  // Reference model: words waiting for the host, plus sticky flags.
  logic [31:0] q[$];
  logic        m_ovf;
  logic        m_done;
  logic [31:0] m_ex;

  function automatic logic [29:0] m_off(input logic [31:0] adr);
    return adr[31:2] - Base[31:2];
  endfunction

  function automatic logic m_hit(input logic [31:0] adr);
    return m_off(adr) < 30'd3;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] adr);
    logic [31:0] r;
    r = 32'd0;
    if (m_hit(adr)) begin
      if (m_off(adr) == 30'd1) r = (32'(m_ovf) << 5) | 32'(q.size());
      else if (m_off(adr) == 30'd2) r = m_ex;
    end
    return r;
  endfunction

  task automatic model_edge();
    logic do_pop, do_push;
    if (reset) begin
      q.delete();
      m_ovf = 1'b0; m_done = 1'b0; m_ex = 32'd0;
    end else begin
      do_pop  = (q.size() != 0) && host_ready;
      do_push = mem_write && m_hit(data_adr) && (m_off(data_adr) == 30'd0);
      if (do_push && q.size() == Depth && !do_pop) begin
        m_ovf = 1'b1;
      end else begin
        if (do_pop) void'(q.pop_front());
        if (do_push) q.push_back(write_data);
      end
      if (mem_write && m_hit(data_adr) && m_off(data_adr) == 30'd1) m_ovf = 1'b0;
      if (mem_write && m_hit(data_adr) && m_off(data_adr) == 30'd2) begin
        m_done = 1'b1;
        m_ex   = write_data;
      end
    end
  endtask

  initial begin
    // rst we adr wd rdy | hit rd val hd done ex
    v(0, 0, 32'h104, 0, 0,  1, 32'h00, 0, 0, 0, 0);   // reset state
    v(0, 1, 32'h100, 7, 0,  1, 32'h00, 0, 0, 0, 0);   // push 7
    v(0, 0, 32'h104, 0, 0,  1, 32'h01, 1, 7, 0, 0);
    v(0, 0, 32'h100, 0, 1,  1, 32'h00, 1, 7, 0, 0);   // drain 7
    v(0, 1, 32'h100, 1, 0,  1, 32'h00, 0, 0, 0, 0);
    v(0, 1, 32'h100, 2, 0,  1, 32'h00, 1, 1, 0, 0);
    v(0, 1, 32'h100, 3, 0,  1, 32'h00, 1, 1, 0, 0);
    v(0, 1, 32'h100, 4, 0,  1, 32'h00, 1, 1, 0, 0);
    v(0, 1, 32'h100, 5, 0,  1, 32'h00, 1, 1, 0, 0);   // dropped
    v(0, 0, 32'h104, 0, 0,  1, 32'h24, 1, 1, 0, 0);
    v(0, 0, 32'h104, 0, 1,  1, 32'h24, 1, 1, 0, 0);
    v(0, 0, 32'h104, 0, 1,  1, 32'h23, 1, 2, 0, 0);
    v(0, 0, 32'h104, 0, 1,  1, 32'h22, 1, 3, 0, 0);
    v(0, 0, 32'h104, 0, 1,  1, 32'h21, 1, 4, 0, 0);
    v(0, 0, 32'h104, 0, 1,  1, 32'h20, 0, 0, 0, 0);
    v(0, 1, 32'h104, 32'hdead, 0, 1, 32'h20, 0, 0, 0, 0);  // clear overflow
    v(0, 0, 32'h104, 0, 0,  1, 32'h00, 0, 0, 0, 0);
    v(0, 1, 32'h100, 1, 0,  1, 32'h00, 0, 0, 0, 0);
    v(0, 1, 32'h100, 2, 0,  1, 32'h00, 1, 1, 0, 0);
    v(0, 1, 32'h100, 3, 0,  1, 32'h00, 1, 1, 0, 0);
    v(0, 1, 32'h100, 4, 0,  1, 32'h00, 1, 1, 0, 0);
    v(0, 1, 32'h100, 9, 1,  1, 32'h00, 1, 1, 0, 0);   // full: push+pop
    v(0, 0, 32'h104, 0, 1,  1, 32'h04, 1, 2, 0, 0);
    v(0, 0, 32'h104, 0, 1,  1, 32'h03, 1, 3, 0, 0);
    v(0, 0, 32'h104, 0, 1,  1, 32'h02, 1, 4, 0, 0);
    v(0, 0, 32'h104, 0, 1,  1, 32'h01, 1, 9, 0, 0);
    v(0, 0, 32'h104, 0, 0,  1, 32'h00, 0, 0, 0, 0);
    v(0, 1, 32'h108, 25, 0, 1, 32'h00, 0, 0, 0, 0);   // halt 25
    v(0, 0, 32'h108, 0, 0,  1, 32'd25, 0, 0, 1, 25);
    v(0, 1, 32'h108, 3, 0,  1, 32'd25, 0, 0, 1, 25);
    v(0, 0, 32'h108, 0, 0,  1, 32'd3,  0, 0, 1, 3);
    v(0, 1, 32'h060, 32'h55, 0, 0, 32'h00, 0, 0, 1, 3); // outside window
    v(0, 0, 32'h104, 0, 0,  1, 32'h00, 0, 0, 1, 3);
    v(0, 0, 32'h10C, 0, 0,  0, 32'h00, 0, 0, 1, 3);
    v(0, 0, 32'h0FC, 0, 0,  0, 32'h00, 0, 0, 1, 3);
    v(0, 0, 32'h10B, 0, 0,  1, 32'd3,  0, 0, 1, 3);   // low bits ignored
    v(0, 1, 32'h100, 32'hA, 0, 1, 32'h00, 0, 0, 1, 3); // push after Done
    v(0, 1, 32'h100, 32'hB, 0, 1, 32'h00, 1, 32'hA, 1, 3);
    v(0, 1, 32'h100, 32'hC, 0, 1, 32'h00, 1, 32'hA, 1, 3);
    v(0, 0, 32'h104, 0, 1,  1, 32'h03, 1, 32'hA, 1, 3);
    v(1, 0, 32'h104, 0, 1,  1, 32'h02, 1, 32'hB, 1, 3); // reset mid-drain
    v(0, 0, 32'h104, 0, 0,  1, 32'h00, 0, 0, 0, 0);
    v(0, 0, 32'h108, 0, 0,  1, 32'h00, 0, 0, 0, 0);

    drive(1, 0, 0, 0, 0);
    repeat (3) @(posedge clk);

    foreach (tbl[i]) begin
      @(posedge clk);
      #1;
      drive(tbl[i].rst, tbl[i].we, tbl[i].adr, tbl[i].wd, tbl[i].rdy);
      @(negedge clk);
      chk($sformatf("tbl%0d Hit", i), 32'(hit), 32'(tbl[i].hit));
      chk($sformatf("tbl%0d ReadData", i), read_data, tbl[i].rd);
      chk($sformatf("tbl%0d HostValid", i), 32'(host_valid), 32'(tbl[i].val));
      if (tbl[i].val) chk($sformatf("tbl%0d HostData", i), host_data, tbl[i].hd);
      chk($sformatf("tbl%0d Done", i), 32'(done), 32'(tbl[i].done));
      chk($sformatf("tbl%0d ExitCode", i), exit_code, tbl[i].ex);
    end

    // Random traffic against the model, starting from reset.
    @(posedge clk);
    #1;
    drive(1, 0, 0, 0, 0);
    @(posedge clk);
    model_edge();
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] adr;
      int unsigned r;
      #1;
      r = $urandom_range(0, 7);
      case (r)
        0, 1, 7: adr = Base + 32'($urandom_range(0, 3));
        2:       adr = Base + 32'd4 + 32'($urandom_range(0, 3));
        3:       adr = Base + 32'd8 + 32'($urandom_range(0, 3));
        4:       adr = Base + 32'hC;
        5:       adr = Base - 32'd4;
        default: adr = $urandom;
      endcase
      drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 1) == 1), adr, $urandom,
            ((n / 40) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
      @(negedge clk);
      chk("rnd Hit", 32'(hit), 32'(m_hit(data_adr)));
      chk("rnd ReadData", read_data, m_read(data_adr));
      chk("rnd HostValid", 32'(host_valid), 32'(q.size() != 0));
      if (q.size() != 0) chk("rnd HostData", host_data, q[0]);
      chk("rnd Done", 32'(done), 32'(m_done));
      chk("rnd ExitCode", exit_code, m_ex);
      @(posedge clk);
      model_edge();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
